// File: rtl/exp_golomb_encoder.sv
`timescale 1ns/1ps
// exp_golomb_encoder
//   Encodes 8-bit symbols as ue(v), se(v), te(v) (range 1) or raw 8-bit
//   codewords. Codewords are packed MSB-first into a 32-bit left-aligned
//   accumulator, and 16-bit words are emitted from its top. A flush drains
//   the full words, then the remaining bits as one zero-padded word.
//
// Ports
//   clk            : clock, rising edge
//   reset_n        : asynchronous active-low reset
//   sym_valid/sym_ready/sym_data/exp_golomb_sel : symbol input handshake
//                    (sel 00=ue 01=se 10=te 11=raw, sampled with the symbol)
//   flush          : single-cycle drain request
//   word_valid/word_ready/word_data : 16-bit packed output handshake
//   fill_level     : valid bits held in the accumulator (0..32)
//   flush_done     : one-cycle pulse when a flush completes
//   bits_written   : total emitted bits, modulo 2^16
//
// Optional feature: define EGE_BITCOUNT_EN to build the bits_written
// counter. Without the macro, bits_written is tied to zero.
module exp_golomb_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic [7:0]  sym_data,
  input  logic [1:0]  exp_golomb_sel,
  input  logic        flush,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [15:0] word_data,
  output logic [5:0]  fill_level,
  output logic        flush_done,
  output logic [15:0] bits_written
);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_acc;
  logic [5:0]  r_fill;
  logic        r_alive;
  logic        r_flush_done;

  logic        w_full;
  logic        w_sym_xfer;
  logic        w_word_xfer;
  logic [8:0]  w_cn1;
  logic [3:0]  w_m;
  logic [16:0] w_code;
  logic [4:0]  w_len;
  logic [5:0]  w_shift;
  logic [31:0] w_code_aligned;

  // se(v) mapping: v>0 -> 2v-1, v<=0 -> -2v (up to 256 for v=-128)
  function automatic logic [8:0] se_codenum(input logic signed [7:0] v);
    logic [8:0] mag;
    if (v > 0) begin
      return {1'b0, v[6:0], 1'b0} - 9'd1;
    end
    mag = 9'd0 - {v[7], v};
    return {mag[7:0], 1'b0};
  endfunction

  function automatic logic [3:0] floor_log2(input logic [8:0] x);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      if (x[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign w_full      = (r_fill >= 6'd16);
  assign sym_ready   = r_alive && (r_state == ST_RUN) && !w_full;
  assign word_valid  = w_full || ((r_state == ST_FLUSH) && (r_fill != 6'd0));
  // Low accumulator bits are always zero, so a partial word is already padded.
  assign word_data   = r_acc[31:16];
  assign fill_level  = r_fill;
  assign flush_done  = r_flush_done;
  assign w_sym_xfer  = sym_valid && sym_ready;
  assign w_word_xfer = word_valid && word_ready;

  // Codeword generation: for ue/se the codeword is codeNum+1 written in
  // 2M+1 bits, i.e. the value itself right-aligned with M leading zeros.
  always_comb begin
    w_cn1  = ((exp_golomb_sel == 2'b01) ? se_codenum(signed'(sym_data))
                                        : {1'b0, sym_data}) + 9'd1;
    w_m    = floor_log2(w_cn1);
    w_code = '0;
    w_len  = '0;
    case (exp_golomb_sel)
      2'b00, 2'b01: begin
        w_code = {8'b0, w_cn1};
        w_len  = {w_m, 1'b1};
      end
      2'b10: begin
        w_code = {16'b0, ~sym_data[0]};
        w_len  = 5'd1;
      end
      default: begin
        w_code = {9'b0, sym_data};
        w_len  = 5'd8;
      end
    endcase
    // Symbols are only accepted with fill<16 and length<=17, so this never underflows.
    w_shift        = 6'd32 - r_fill - {1'b0, w_len};
    w_code_aligned = {15'b0, w_code} << w_shift;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (flush) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_fill == 6'd0) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_RUN;
      r_acc        <= '0;
      r_fill       <= '0;
      r_alive      <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_alive      <= 1'b1;
      r_flush_done <= (r_state == ST_FLUSH) && (r_fill == 6'd0);
      // Word and symbol transfers are mutually exclusive: sym_ready needs
      // RUN with fill<16, word_valid needs fill>=16 or FLUSH.
      if (w_word_xfer) begin
        if (w_full) begin
          r_acc  <= r_acc << 16;
          r_fill <= r_fill - 6'd16;
        end else begin
          r_acc  <= '0;
          r_fill <= '0;
        end
      end else if (w_sym_xfer) begin
        r_acc  <= r_acc | w_code_aligned;
        r_fill <= r_fill + {1'b0, w_len};
      end
    end
  end

`ifdef EGE_BITCOUNT_EN
  logic [15:0] r_bits;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bits <= '0;
    end else if (w_word_xfer) begin
      r_bits <= r_bits + (w_full ? 16'd16 : {10'b0, r_fill});
    end
  end

  assign bits_written = r_bits;
`else
  assign bits_written = '0;
`endif

endmodule

// File: doc/exp_golomb_encoder.md
EXP_GOLOMB_ENCODER -- requirements
Module: exp_golomb_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port sym_valid, input, 1 bit: a symbol is offered.
REQ-004 SHALL have port sym_ready, output, 1 bit: the encoder accepts the symbol this cycle.
REQ-005 SHALL have port sym_data, input, 8 bits: symbol value, unsigned or two's complement per mode.
REQ-006 SHALL have port exp_golomb_sel, input, 2 bits, sampled with the symbol: 00 = ue(v), 01 = se(v), 10 = te(v) with range 1, 11 = raw 8-bit.
REQ-007 SHALL have port flush, input, 1 bit: single-cycle request to drain and zero-pad.
REQ-008 SHALL have port word_valid, output, 1 bit: word_data holds a packed word.
REQ-009 SHALL have port word_ready, input, 1 bit: the downstream consumer takes the word.
REQ-010 SHALL have port word_data, output, 16 bits: packed bitstream, MSB = earliest bit.
REQ-011 SHALL have port fill_level, output, 6 bits: valid bits held in the accumulator (0..32).
REQ-012 SHALL have port flush_done, output, 1 bit: one-cycle pulse when a flush completes.
REQ-013 SHALL have port bits_written, output, 16 bits: total bits emitted (see Configuration).

Function
REQ-014 SHALL transfer a symbol only when sym_valid=1 and sym_ready=1 in the same cycle.
REQ-015 SHALL transfer a word only when word_valid=1 and word_ready=1 in the same cycle.
REQ-016 SHALL drive sym_ready=1 only in state RUN with fill_level<16.
REQ-017 SHALL drive word_valid=1 whenever fill_level>=16, and in FLUSH whenever fill_level is 1..15 (partial word).
REQ-018 SHALL encode ue as codeNum=v: M=floor(log2(codeNum+1)), M zeros, then codeNum+1 in M+1 bits; length 2M+1 (1..17).
REQ-019 SHALL map se with v>0 to codeNum=2v-1 and v<=0 to codeNum=-2v (maximum 256, length 17), then encode as ue.
REQ-020 SHALL encode te as the single bit !v[0].
REQ-021 SHALL encode raw as the 8 bits of sym_data.
REQ-022 SHALL append the codeword MSB-first into a 32-bit left-aligned accumulator and make it visible in fill_level one cycle after acceptance.
REQ-023 SHALL present the top 16 accumulator bits on word_data, and on a word transfer shift left by 16 and subtract 16 from fill_level.
REQ-024 SHALL pad a partial word with zeros in its low bits; its transfer sets fill_level to 0.
REQ-025 SHALL implement states RUN and FLUSH; flush=1 in RUN moves to FLUSH on the next edge, and a symbol accepted in the same cycle is encoded before padding.
REQ-026 SHALL hold sym_ready=0 in FLUSH, drain full words then the padded partial word, and return to RUN when fill_level=0 with flush_done pulsed for one cycle.
REQ-027 SHALL treat flush in FLUSH as a no-op, and flush with fill_level=0 as a one-cycle FLUSH followed by flush_done with no word emitted.
REQ-028 SHALL hold word_data and word_valid stable while word_valid=1 and word_ready=0.

Reset
REQ-029 SHALL, while reset_n=0, force state=RUN, clear the accumulator, and drive fill_level=0, sym_ready=0, word_valid=0, word_data=0, flush_done=0, bits_written=0.
REQ-030 SHALL, on reset mid-operation, discard all buffered bits and any pending flush; sym_ready rises on the first edge after release.

Configuration
REQ-031 SHALL, with EGE_BITCOUNT_EN defined, increment bits_written by 16 per full word and by the valid bit count per padded word, wrapping modulo 2^16.
REQ-032 SHALL, with EGE_BITCOUNT_EN undefined, tie bits_written to 0 and omit the counter logic.

Verification
REQ-033 SHALL cover: ue(0), ue(3), se(-1), then flush -> one word 0x9180, flush_done pulse, fill_level 0.
REQ-034 SHALL cover: sixteen ue(0) -> word_data=0xFFFF, then fill_level 0.
REQ-035 SHALL cover: ue(255), then flush -> words 0x0080, 0x0000; bits_written=17 with EGE_BITCOUNT_EN.
REQ-036 SHALL cover: word_ready=0 for 5 cycles with fill_level>=16 -> sym_ready=0 and word_data stable; release -> transfer.
REQ-037 SHALL cover: flush with fill_level=0 -> flush_done after one cycle and no word_valid.
REQ-038 SHALL cover: reset_n low during FLUSH with 9 bits buffered -> all outputs reset, no word emitted after release.
